inst_mem_responder: RTL and testbench
=====================================

INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64: number of 32-bit instruction words stored.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to response valid; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid_in, input, 1 bit: the fetch stage presents an address.
REQ-006 SHALL have port req_addr_in, input, 32 bits: byte address of the fetch.
REQ-007 SHALL have port req_ready_out, output, 1 bit: the block can accept a request.
REQ-008 SHALL have port flush_in, input, 1 bit: branch taken; cancels the outstanding fetch.
REQ-009 SHALL have port resp_valid_out, output, 1 bit: response is valid.
REQ-010 SHALL have port resp_ready_in, input, 1 bit: the fetch stage consumes the response.
REQ-011 SHALL have port resp_instr_out, output, 32 bits: fetched instruction word.
REQ-012 SHALL have port resp_err_out, output, 1 bit: the address was out of range.
REQ-013 SHALL have port load_we_in, input, 1 bit: program-load write strobe.
REQ-014 SHALL have port load_addr_in, input, 32 bits: byte address of the program-load write.
REQ-015 SHALL have port load_data_in, input, 32 bits: instruction word to store.

Function
REQ-016 SHALL force address bits [1:0] to zero for both read and load; word index = addr[31:2].
REQ-017 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-018 SHALL drive req_ready_out=1 only in IDLE, and SHALL accept a request when req_valid_in & req_ready_out & ~flush_in.
REQ-019 SHALL, on acceptance, capture the memory word (or the error result) and load the latency counter with LATENCY-1; the FSM goes to RESP if LATENCY==1, else to WAIT.
REQ-020 SHALL decrement the counter every cycle in WAIT and go to RESP when the counter reaches 0; the first response cycle is therefore exactly LATENCY cycles after the acceptance edge.
REQ-021 SHALL assert resp_valid_out only in RESP, holding resp_instr_out and resp_err_out stable until resp_ready_in=1; the FSM then returns to IDLE.
REQ-022 SHALL give out-of-range addresses (word index >= DEPTH_WORDS) resp_err_out=1 and resp_instr_out=32'hE1A00000 (NOP).
REQ-023 SHALL, when flush_in=1 in WAIT or RESP, drop the fetch and go to IDLE with no response; flush has priority over resp_ready_in.
REQ-024 SHALL ignore flush_in=1 in IDLE, and SHALL not accept a request in that cycle.
REQ-025 SHALL perform a load write on any cycle with load_we_in=1 when the address is in range; out-of-range loads are dropped silently.
REQ-026 SHALL not alter a captured response with a load write; a load to the same word in the acceptance cycle is not visible to that fetch.
REQ-027 SHALL accept back-to-back requests at most one per LATENCY+1 cycles; no pipelining.

Reset
REQ-028 SHALL, while rst=0, immediately force: state IDLE, counter 0, resp_valid_out=0, resp_err_out=0, resp_instr_out=0 and req_ready_out=1.
REQ-029 SHALL not reset memory contents.
REQ-030 SHALL discard any in-flight fetch on reset mid-operation, with no response after release.

Structure
REQ-031 SHALL place the FSM state encoding and the NOP constant 32'hE1A00000 in shared package arm_pkg.
REQ-032 SHALL isolate the storage in one sub-module, inst_mem_array: synchronous write, combinational read, DEPTH_WORDS parameter.

Verification
REQ-033 SHALL verify basic fetch: load word 0xE3A00014 to address 0; LATENCY=2, request addr 0 -> resp_valid 2 cycles after acceptance, instr 0xE3A00014, err 0.
REQ-034 SHALL verify unaligned access: load 0xE3A01A01 to address 4, request addr 0x7 -> instr 0xE3A01A01.
REQ-035 SHALL verify out-of-range access: request addr 256 with DEPTH_WORDS=64 -> err 1, instr 0xE1A00000.
REQ-036 SHALL verify backpressure: hold resp_ready_in=0 for 5 cycles -> resp_valid and data stable for all 5; IDLE the cycle after ready=1.
REQ-037 SHALL verify flush: flush_in=1 in WAIT -> no resp_valid; req_ready_out=1 the next cycle; the following request returns correct data.
REQ-038 SHALL verify reset mid-fetch: rst=0 in WAIT -> resp_valid_out=0 and req_ready_out=1 immediately; no response after release.

Source files
------------

// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the instruction-memory responder:
//   fsm_state_e  - responder FSM state encoding (IDLE / WAIT / RESP)
//   NOP_INSTR    - instruction returned for out-of-range fetches
//   CNT_W        - latency counter width (covers LATENCY up to 15)
//   idx_in_range - word-index bounds check shared by read and load paths
// -----------------------------------------------------------------------------
package arm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fsm_state_e;

  // ARM "MOV r0, r0"
  localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

  localparam int CNT_W = 4;

  function automatic logic idx_in_range(input logic [29:0] word_idx,
                                        input int          depth_words);
    return word_idx < 30'(depth_words);
  endfunction

endpackage

// File: rtl/inst_mem_responder_if.sv
// -----------------------------------------------------------------------------
// inst_mem_responder_if
// Bundles the fetch request/response handshake and the program-load port.
//   slave  : the responder (drives req_ready_out and the resp_* outputs)
//   master : the fetch stage / program loader
// -----------------------------------------------------------------------------
interface inst_mem_responder_if;

  logic        req_valid_in;
  logic [31:0] req_addr_in;
  logic        req_ready_out;
  logic        flush_in;
  logic        resp_valid_out;
  logic        resp_ready_in;
  logic [31:0] resp_instr_out;
  logic        resp_err_out;
  logic        load_we_in;
  logic [31:0] load_addr_in;
  logic [31:0] load_data_in;

  modport slave (
    input  req_valid_in, req_addr_in, flush_in, resp_ready_in,
           load_we_in, load_addr_in, load_data_in,
    output req_ready_out, resp_valid_out, resp_instr_out, resp_err_out
  );

  modport master (
    output req_valid_in, req_addr_in, flush_in, resp_ready_in,
           load_we_in, load_addr_in, load_data_in,
    input  req_ready_out, resp_valid_out, resp_instr_out, resp_err_out
  );

endinterface

// File: rtl/inst_mem_array.sv
// -----------------------------------------------------------------------------
// inst_mem_array
// Instruction word storage: synchronous write, combinational read.
//   clk     - write clock
//   i_we    - write enable (already qualified as in range by the caller)
//   i_waddr - write word index
//   i_wdata - write data
//   i_raddr - read word index
//   o_rdata - read data (current contents, before any same-cycle write)
// -----------------------------------------------------------------------------
module inst_mem_array #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // NOTE: storage has no reset; a program image survives a core reset and a
  // reset port would stop this mapping onto RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_mem_responder.sv
// -----------------------------------------------------------------------------
// inst_mem_responder
// Single-outstanding instruction fetch responder with fixed latency.
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous, active-low reset
//   bus  - slave side of inst_mem_responder_if:
//          req_valid_in/req_addr_in/req_ready_out : fetch request
//          flush_in                               : cancel outstanding fetch
//          resp_valid_out/resp_ready_in           : response handshake
//          resp_instr_out/resp_err_out            : fetched word / range error
//          load_we_in/load_addr_in/load_data_in   : program-load write port
// The response is captured at acceptance, so later loads never alter it and
// a load to the same word in the acceptance cycle is not seen by that fetch.
// -----------------------------------------------------------------------------
module inst_mem_responder
  import arm_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2     // legal range 1..15
) (
  input  logic                 clk,
  input  logic                 rst,
  inst_mem_responder_if.slave  bus
);

  localparam int              AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  fsm_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]      r_instr;
  logic             r_err;

  logic [29:0] w_rd_idx, w_ld_idx;
  logic        w_rd_in_range, w_ld_in_range;
  logic        w_accept, w_ld_we;
  logic [31:0] w_rd_data;

  // Byte-offset bits are ignored on both paths.
  logic [3:0]  w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = {bus.req_addr_in[1:0], bus.load_addr_in[1:0]};

  assign w_rd_idx      = bus.req_addr_in[31:2];
  assign w_ld_idx      = bus.load_addr_in[31:2];
  assign w_rd_in_range = idx_in_range(w_rd_idx, DEPTH_WORDS);
  assign w_ld_in_range = idx_in_range(w_ld_idx, DEPTH_WORDS);
  assign w_ld_we       = bus.load_we_in & w_ld_in_range;

  assign w_accept = (r_state == ST_IDLE) & bus.req_valid_in & ~bus.flush_in;

  inst_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_ld_we),
    .i_waddr (w_ld_idx[AW-1:0]),
    .i_wdata (bus.load_data_in),
    .i_raddr (w_rd_idx[AW-1:0]),
    .o_rdata (w_rd_data)
  );

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statement leaves a latch behind.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.flush_in) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          // Counter was loaded with LATENCY-1 and has drained one per cycle,
          // so this edge is LATENCY cycles after acceptance.
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_RESP: begin
        // Flush and consume both return to IDLE; flush drops the response.
        if (bus.flush_in || bus.resp_ready_in) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_instr <= w_rd_in_range ? w_rd_data : NOP_INSTR;
      r_err   <= ~w_rd_in_range;
    end
  end

  assign bus.req_ready_out  = (r_state == ST_IDLE);
  assign bus.resp_valid_out = (r_state == ST_RESP);
  assign bus.resp_instr_out = r_instr;
  assign bus.resp_err_out   = r_err;

endmodule

// File: tb/tb_inst_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_inst_mem_responder
// Directed and randomized fetches against a behavioural model: a plain word
// array updated by in-range loads, a fetch returns the array word (or NOP
// with err) as seen before its acceptance edge, LATENCY cycles later.
// -----------------------------------------------------------------------------
module tb_inst_mem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;
  localparam logic [31:0] NOP = 32'hE1A00000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_mem_responder_if bus ();

  inst_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] model_mem [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_in_range(input logic [31:0] a);
    return (a / 4) < DEPTH;
  endfunction

  function automatic logic [31:0] model_instr(input logic [31:0] a);
    return model_in_range(a) ? model_mem[a / 4] : NOP;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    if (model_in_range(a)) model_mem[a / 4] = d;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    bus.load_we_in   = 1'b1;
    bus.load_addr_in = a;
    bus.load_data_in = d;
    step();
    bus.load_we_in   = 1'b0;
    model_write(a, d);
  endtask

  // One complete fetch: request, latency measurement, optional backpressure
  // for 'hold' cycles, then consume. Optionally issues a load in the same
  // cycle as the request.
  task automatic fetch(input logic [31:0] addr, input int hold,
                       input bit ld, input logic [31:0] ld_addr,
                       input logic [31:0] ld_data);
    logic [31:0] exp_instr;
    logic        exp_err;
    int          n;
    exp_instr = model_instr(addr);
    exp_err   = ~model_in_range(addr);
    check("req_ready_idle", 32'(bus.req_ready_out), 32'd1);
    bus.req_valid_in = 1'b1;
    bus.req_addr_in  = addr;
    if (ld) begin
      bus.load_we_in   = 1'b1;
      bus.load_addr_in = ld_addr;
      bus.load_data_in = ld_data;
    end
    step();
    bus.req_valid_in = 1'b0;
    bus.load_we_in   = 1'b0;
    if (ld) model_write(ld_addr, ld_data);
    check("req_ready_busy", 32'(bus.req_ready_out), 32'd0);
    n = 0;
    while (bus.resp_valid_out !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("latency", 32'(n), 32'(LAT));
    check("instr", bus.resp_instr_out, exp_instr);
    check("err", 32'(bus.resp_err_out), 32'(exp_err));
    for (int k = 0; k < hold; k++) begin
      step();
      check("hold_valid", 32'(bus.resp_valid_out), 32'd1);
      check("hold_instr", bus.resp_instr_out, exp_instr);
      check("hold_err", 32'(bus.resp_err_out), 32'(exp_err));
    end
    bus.resp_ready_in = 1'b1;
    step();
    bus.resp_ready_in = 1'b0;
    check("valid_after_consume", 32'(bus.resp_valid_out), 32'd0);
    check("ready_after_consume", 32'(bus.req_ready_out), 32'd1);
  endtask

  task automatic expect_silence(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      check(tag, 32'(bus.resp_valid_out), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] a;
    rst               = 1'b0;
    bus.req_valid_in  = 1'b0;
    bus.req_addr_in   = '0;
    bus.flush_in      = 1'b0;
    bus.resp_ready_in = 1'b0;
    bus.load_we_in    = 1'b0;
    bus.load_addr_in  = '0;
    bus.load_data_in  = '0;

    // Reset state.
    #2;
    check("rst_valid", 32'(bus.resp_valid_out), 32'd0);
    check("rst_ready", 32'(bus.req_ready_out), 32'd1);
    check("rst_instr", bus.resp_instr_out, 32'd0);
    check("rst_err",   32'(bus.resp_err_out), 32'd0);
    step();
    step();
    rst = 1'b1;

    // Fill the whole memory so every in-range read has a defined value.
    for (int i = 0; i < DEPTH; i++) do_load(32'(i * 4), $urandom);

    // Basic fetch.
    do_load(32'h0, 32'hE3A00014);
    fetch(32'h0, 0, 1'b0, '0, '0);

    // Unaligned access.
    do_load(32'h4, 32'hE3A01A01);
    fetch(32'h7, 0, 1'b0, '0, '0);

    // Out of range, and an out-of-range load must not alias onto word 0.
    fetch(32'd256, 0, 1'b0, '0, '0);
    do_load(32'h100, 32'hDEADBEEF);
    fetch(32'h0, 0, 1'b0, '0, '0);

    // Backpressure for 5 cycles.
    fetch(32'h4, 5, 1'b0, '0, '0);

    // Load to the fetched word in the acceptance cycle: old data returned,
    // new data visible to the next fetch.
    fetch(32'h8, 0, 1'b1, 32'h8, 32'h12345678);
    fetch(32'h8, 0, 1'b0, '0, '0);

    // Flush in WAIT.
    bus.req_valid_in = 1'b1;
    bus.req_addr_in  = 32'h0;
    step();
    bus.req_valid_in = 1'b0;
    bus.flush_in     = 1'b1;
    step();
    bus.flush_in     = 1'b0;
    check("flush_wait_valid", 32'(bus.resp_valid_out), 32'd0);
    check("flush_wait_ready", 32'(bus.req_ready_out), 32'd1);
    expect_silence("flush_wait_silent", LAT + 2);
    fetch(32'h4, 0, 1'b0, '0, '0);

    // Flush in RESP together with ready: response dropped, back to IDLE.
    bus.req_valid_in = 1'b1;
    bus.req_addr_in  = 32'hC;
    step();
    bus.req_valid_in = 1'b0;
    for (int i = 0; i < LAT; i++) step();
    check("pre_flush_resp_valid", 32'(bus.resp_valid_out), 32'd1);
    bus.flush_in      = 1'b1;
    bus.resp_ready_in = 1'b1;
    step();
    bus.flush_in      = 1'b0;
    bus.resp_ready_in = 1'b0;
    check("flush_resp_valid", 32'(bus.resp_valid_out), 32'd0);
    check("flush_resp_ready", 32'(bus.req_ready_out), 32'd1);

    // Flush in IDLE blocks acceptance that cycle.
    bus.req_valid_in = 1'b1;
    bus.req_addr_in  = 32'h0;
    bus.flush_in     = 1'b1;
    step();
    bus.req_valid_in = 1'b0;
    bus.flush_in     = 1'b0;
    check("flush_idle_ready", 32'(bus.req_ready_out), 32'd1);
    expect_silence("flush_idle_silent", LAT + 2);

    // Reset in WAIT: outputs clear immediately, no response after release,
    // memory contents kept.
    bus.req_valid_in = 1'b1;
    bus.req_addr_in  = 32'h4;
    step();
    bus.req_valid_in = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.resp_valid_out), 32'd0);
    check("midrst_ready", 32'(bus.req_ready_out), 32'd1);
    check("midrst_instr", bus.resp_instr_out, 32'd0);
    step();
    rst = 1'b1;
    expect_silence("midrst_silent", LAT + 3);
    fetch(32'h4, 1, 1'b0, '0, '0);

    // Randomized traffic, including some out-of-range loads and fetches.
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 2) == 0) do_load($urandom_range(0, 32'h11F), $urandom);
      a = $urandom_range(0, 32'h11F);
      fetch(a, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
            $urandom_range(0, 32'h11F), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
